// File: rtl/snake_frame_renderer.sv
// Snake game pixel stage: grid occupancy bitmap with a wipe FSM, plus a
// two-stage render pipeline producing RGB with delay-matched HS/VS.
module snake_frame_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int CELL_LOG2 = 4,
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       hsIn,
  input  logic       vsIn,
  input  logic       wrValid,
  output logic       wrReady,
  input  logic [5:0] wrX,
  input  logic [4:0] wrY,
  input  logic       wrSet,
  input  logic [5:0] headX,
  input  logic [4:0] headY,
  input  logic [5:0] foodX,
  input  logic [4:0] foodY,
  input  logic       wallsOn,
  input  logic       gameOver,
  input  logic       clearStart,
  output logic       clearBusy,
  output logic       HS,
  output logic       VS,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue
);

  localparam int CELLS  = GRID_W * GRID_H;
  localparam int ADDR_W = $clog2(CELLS);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                ready_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_IDLE: if (clearStart) begin
        state_d    = S_CLEAR;
        clr_addr_d = '0;
      end
      S_CLEAR: begin
        if (clr_addr_q == ADDR_W'(CELLS - 1)) state_d = S_IDLE;
        else clr_addr_d = clr_addr_q + 1'b1;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Ready is registered from the next state so it lines up with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= (state_d == S_IDLE);
    end
  end

  assign wrReady   = ready_q;
  assign clearBusy = ~ready_q;

  logic              wr_in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data;

  assign wr_in_range = (wrX < 6'(GRID_W)) && (wrY < 5'(GRID_H));

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = 1'b0;
    if (state_q == S_CLEAR) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr_q;
    end else if (wrValid && ready_q && wr_in_range) begin
      mem_we   = 1'b1;
      mem_addr = ADDR_W'(wrY) * ADDR_W'(GRID_W) + ADDR_W'(wrX);
      mem_data = wrSet;
    end
  end

  logic bitmap_q [CELLS];

  // NOTE: the bitmap has no reset; the wipe FSM started by reset zeroes it.
  always_ff @(posedge clock) begin
    if (mem_we) bitmap_q[mem_addr] <= mem_data;
  end

  // Stage 1: raster decode and synchronous bitmap read (old data on same-cycle write).
  logic              active_d;
  logic [5:0]        cell_x_d;
  logic [4:0]        cell_y_d;
  logic [ADDR_W-1:0] rd_addr_d;

  assign active_d  = (hCount < 10'(H_ACTIVE)) && (vCount < 10'(V_ACTIVE));
  assign cell_x_d  = 6'(hCount >> CELL_LOG2);
  assign cell_y_d  = 5'(vCount >> CELL_LOG2);
  assign rd_addr_d = active_d ? ADDR_W'(cell_y_d) * ADDR_W'(GRID_W) + ADDR_W'(cell_x_d) : '0;

  logic       active_q, body_q, hs1_q, vs1_q;
  logic [5:0] cell_x_q;
  logic [4:0] cell_y_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q <= 1'b0;
      body_q   <= 1'b0;
      cell_x_q <= '0;
      cell_y_q <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      body_q   <= bitmap_q[rd_addr_d];
      cell_x_q <= cell_x_d;
      cell_y_q <= cell_y_d;
      hs1_q    <= hsIn;
      vs1_q    <= vsIn;
    end
  end

  // Stage 2: classify by priority; game-over turns every lit pixel red.
  logic        head_hit, food_hit, wall_hit;
  logic [11:0] rgb_d, rgb_q;
  logic        hs2_q, vs2_q;

  assign head_hit = (cell_x_q == headX) && (cell_y_q == headY);
  assign food_hit = (cell_x_q == foodX) && (cell_y_q == foodY);
  assign wall_hit = wallsOn && (cell_x_q == '0 || cell_x_q == 6'(GRID_W - 1) ||
                                cell_y_q == '0 || cell_y_q == 5'(GRID_H - 1));

  always_comb begin
    rgb_d = 12'h000;
    if (!active_q)     rgb_d = 12'h000;
    else if (head_hit) rgb_d = 12'h0f0;
    else if (body_q)   rgb_d = 12'h080;
    else if (food_hit) rgb_d = 12'hf00;
    else if (wall_hit) rgb_d = 12'h888;
    if (gameOver && rgb_d != 12'h000) rgb_d = 12'hf00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rgb_q <= 12'h000;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign HS    = hs2_q;
  assign VS    = vs2_q;
  assign Red   = rgb_q[11:8];
  assign Green = rgb_q[7:4];
  assign Blue  = rgb_q[3:0];

endmodule

// File: tb/tb_snake_frame_renderer.sv
// Directed bench for snake_frame_renderer: wipe timing, write handshake,
// pixel priority, pipeline latency and sync alignment.
module tb_snake_frame_renderer;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] hCount, vCount;
  logic       hsIn, vsIn;
  logic       wrValid, wrReady, wrSet;
  logic [5:0] wrX, headX, foodX;
  logic [4:0] wrY, headY, foodY;
  logic       wallsOn, gameOver, clearStart, clearBusy;
  logic       HS, VS;
  logic [3:0] Red, Green, Blue;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  snake_frame_renderer dut (
    .clock(clock), .reset(reset), .hCount(hCount), .vCount(vCount),
    .hsIn(hsIn), .vsIn(vsIn), .wrValid(wrValid), .wrReady(wrReady),
    .wrX(wrX), .wrY(wrY), .wrSet(wrSet), .headX(headX), .headY(headY),
    .foodX(foodX), .foodY(foodY), .wallsOn(wallsOn), .gameOver(gameOver),
    .clearStart(clearStart), .clearBusy(clearBusy), .HS(HS), .VS(VS),
    .Red(Red), .Green(Green), .Blue(Blue)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic get_pix(input int h, input int v, output logic [11:0] rgb);
    hCount = 10'(h);
    vCount = 10'(v);
    tick;
    tick;
    rgb = {Red, Green, Blue};
  endtask

  task automatic do_write(input int x, input int y, input logic set);
    wrValid = 1'b1;
    wrX = 6'(x);
    wrY = 5'(y);
    wrSet = set;
    tick;
    wrValid = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    int ph[3] = '{0, 320, 639};
    int pv[3] = '{0, 240, 479};
    logic [11:0] got;
    reset = 1'b1;
    tick;
    tick;
    n_total++;
    if ({wrReady, clearBusy} !== 2'b01)
      $display("FAIL reset_handshake: got ready/busy=%b expected 01", {wrReady, clearBusy});
    else n_pass++;
    n_total++;
    if ({HS, VS, Red, Green, Blue} !== 14'b11_0000_0000_0000)
      $display("FAIL reset_outputs: got hs/vs/rgb=%h expected %h", {HS, VS, Red, Green, Blue}, 14'h3000);
    else n_pass++;
    reset = 1'b0;
    n = 0;
    while (clearBusy === 1'b1 && n < 2000) begin
      n_total += (wrReady !== 1'b0) ? 1 : 0;
      if (wrReady !== 1'b0) $display("FAIL ready_during_wipe: got %b expected 0 at %0d", wrReady, n);
      tick;
      n++;
    end
    n_total++;
    if (n != 1200) $display("FAIL wipe_length_reset: got %0d expected 1200", n);
    else n_pass++;
    n_total++;
    if (wrReady !== 1'b1) $display("FAIL ready_after_wipe: got %b expected 1", wrReady);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      get_pix(ph[i], pv[i], got);
      n_total++;
      if (got !== 12'h000) $display("FAIL blank_pixel(%0d,%0d): got %h expected 000", ph[i], pv[i], got);
      else n_pass++;
    end
  endtask

  task automatic test_body_row;
    logic [11:0] exp;
    int v;
    do_write(5, 3, 1'b1);
    for (int r = 0; r < 2; r++) begin
      v = (r == 0) ? 48 : 63;
      for (int h = 78; h <= 97; h++) begin
        hCount = 10'(h);
        vCount = 10'(v);
        tick;
        // Output after this edge belongs to the count driven one iteration earlier.
        if (h > 78) begin
          exp = (h - 1 >= 80 && h - 1 <= 95) ? 12'h080 : 12'h000;
          n_total++;
          if ({Red, Green, Blue} !== exp)
            $display("FAIL body_row(%0d,%0d): got %h expected %h", h - 1, v, {Red, Green, Blue}, exp);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_head_gameover;
    logic [11:0] got;
    headX = 6'd5;
    headY = 5'd3;
    get_pix(80, 48, got);
    n_total++;
    if (got !== 12'h0f0) $display("FAIL head_pixel: got %h expected 0f0", got);
    else n_pass++;
    foodX = 6'd10;
    foodY = 5'd10;
    get_pix(160, 160, got);
    n_total++;
    if (got !== 12'hf00) $display("FAIL food_pixel: got %h expected f00", got);
    else n_pass++;
    // gameOver changes between the two edges and must still take effect.
    hCount = 10'd80;
    vCount = 10'd48;
    tick;
    gameOver = 1'b1;
    tick;
    n_total++;
    if ({Red, Green, Blue} !== 12'hf00) $display("FAIL head_gameover: got %h expected f00", {Red, Green, Blue});
    else n_pass++;
    get_pix(200, 200, got);
    n_total++;
    if (got !== 12'h000) $display("FAIL bg_gameover: got %h expected 000", got);
    else n_pass++;
    headX = 6'd63;
    headY = 5'd31;
    get_pix(90, 60, got);
    n_total++;
    if (got !== 12'hf00) $display("FAIL body_gameover: got %h expected f00", got);
    else n_pass++;
    gameOver = 1'b0;
    foodX = 6'd63;
    foodY = 5'd31;
  endtask

  task automatic test_walls_sync;
    int          ph[4]  = '{0, 639, 640, 0};
    int          pv[4]  = '{0, 479, 0, 480};
    logic [11:0] exp[4] = '{12'h888, 12'h888, 12'h000, 12'h000};
    logic [11:0] got;
    wallsOn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      get_pix(ph[i], pv[i], got);
      n_total++;
      if (got !== exp[i]) $display("FAIL wall(%0d,%0d): got %h expected %h", ph[i], pv[i], got, exp[i]);
      else n_pass++;
    end
    wallsOn = 1'b0;
    hsIn = 1'b0;
    tick;
    n_total++;
    if (HS !== 1'b1) $display("FAIL hs_early: got %b expected 1", HS);
    else n_pass++;
    tick;
    n_total++;
    if (HS !== 1'b0) $display("FAIL hs_delay2: got %b expected 0", HS);
    else n_pass++;
    hsIn = 1'b1;
    vsIn = 1'b0;
    tick;
    n_total++;
    if ({HS, VS} !== 2'b01) $display("FAIL sync_step1: got hs/vs=%b expected 01", {HS, VS});
    else n_pass++;
    tick;
    n_total++;
    if ({HS, VS} !== 2'b10) $display("FAIL sync_step2: got hs/vs=%b expected 10", {HS, VS});
    else n_pass++;
    vsIn = 1'b1;
    tick;
    tick;
  endtask

  task automatic test_rbw_range;
    logic [11:0] got;
    hCount = 10'd112;
    vCount = 10'd32;
    tick;
    tick;
    for (int s = 1; s >= 0; s--) begin
      wrValid = 1'b1;
      wrX = 6'd7;
      wrY = 5'd2;
      wrSet = 1'(s);
      n_total++;
      if (wrReady !== 1'b1) $display("FAIL rbw_ready: got %b expected 1", wrReady);
      else n_pass++;
      tick;
      wrValid = 1'b0;
      tick;
      n_total++;
      if ({Red, Green, Blue} !== (s ? 12'h000 : 12'h080))
        $display("FAIL rbw_old(set=%0d): got %h expected %h", s, {Red, Green, Blue}, s ? 12'h000 : 12'h080);
      else n_pass++;
      tick;
      n_total++;
      if ({Red, Green, Blue} !== (s ? 12'h080 : 12'h000))
        $display("FAIL rbw_new(set=%0d): got %h expected %h", s, {Red, Green, Blue}, s ? 12'h080 : 12'h000);
      else n_pass++;
    end
    wrValid = 1'b1;
    wrX = 6'd40;
    wrY = 5'd2;
    wrSet = 1'b1;
    n_total++;
    if (wrReady !== 1'b1) $display("FAIL oor_ready: got %b expected 1", wrReady);
    else n_pass++;
    tick;
    do_write(63, 0, 1'b1);
    get_pix(0, 48, got);
    n_total++;
    if (got !== 12'h000) $display("FAIL oor_x40: got %h expected 000", got);
    else n_pass++;
    get_pix(368, 16, got);
    n_total++;
    if (got !== 12'h000) $display("FAIL oor_x63: got %h expected 000", got);
    else n_pass++;
  endtask

  task automatic test_clear_busy;
    int cnt;
    logic [11:0] got;
    clearStart = 1'b1;
    tick;
    clearStart = 1'b0;
    n_total++;
    if ({wrReady, clearBusy} !== 2'b01) $display("FAIL clear_start: got ready/busy=%b expected 01", {wrReady, clearBusy});
    else n_pass++;
    cnt = 0;
    while (clearBusy === 1'b1 && cnt < 3000) begin
      if (cnt == 5) begin
        wrValid = 1'b1;
        wrX = 6'd9;
        wrY = 5'd4;
        wrSet = 1'b1;
      end
      if (cnt == 100) clearStart = 1'b1;
      tick;
      clearStart = 1'b0;
      cnt++;
    end
    n_total++;
    if (cnt != 1200) $display("FAIL wipe_length_restart_ignored: got %0d expected 1200", cnt);
    else n_pass++;
    n_total++;
    if (wrReady !== 1'b1) $display("FAIL held_write_ready: got %b expected 1", wrReady);
    else n_pass++;
    tick;
    wrValid = 1'b0;
    get_pix(144, 64, got);
    n_total++;
    if (got !== 12'h080) $display("FAIL held_write_lands: got %h expected 080", got);
    else n_pass++;
    get_pix(80, 48, got);
    n_total++;
    if (got !== 12'h000) $display("FAIL body_wiped: got %h expected 000", got);
    else n_pass++;
  endtask

  task automatic test_reset_mid_wipe;
    int cnt;
    logic [11:0] got;
    hsIn = 1'b0;
    vsIn = 1'b0;
    hCount = 10'd144;
    vCount = 10'd64;
    clearStart = 1'b1;
    tick;
    clearStart = 1'b0;
    repeat (599) tick;
    reset = 1'b1;
    tick;
    n_total++;
    if ({HS, VS, Red, Green, Blue, clearBusy} !== 15'b11_0000_0000_0000_1)
      $display("FAIL midwipe_reset_outputs: got %h expected %h", {HS, VS, Red, Green, Blue, clearBusy}, 15'h6001);
    else n_pass++;
    reset = 1'b0;
    hsIn = 1'b1;
    vsIn = 1'b1;
    cnt = 0;
    while (clearBusy === 1'b1 && cnt < 3000) begin
      tick;
      cnt++;
    end
    n_total++;
    if (cnt != 1200) $display("FAIL wipe_length_after_reset: got %0d expected 1200", cnt);
    else n_pass++;
    get_pix(144, 64, got);
    n_total++;
    if (got !== 12'h000) $display("FAIL cell_wiped_after_reset: got %h expected 000", got);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    hCount = '0;
    vCount = '0;
    hsIn = 1'b1;
    vsIn = 1'b1;
    wrValid = 1'b0;
    wrX = '0;
    wrY = '0;
    wrSet = 1'b0;
    headX = 6'd63;
    headY = 5'd31;
    foodX = 6'd63;
    foodY = 5'd31;
    wallsOn = 1'b0;
    gameOver = 1'b0;
    clearStart = 1'b0;
    test_reset;
    test_body_row;
    test_head_gameover;
    test_walls_sync;
    test_rbw_range;
    test_clear_busy;
    test_reset_mid_wipe;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snake_frame_renderer.md
Name: snake_frame_renderer

Overview:
- Downstream pixel stage of the snake game.
- Consumes VGA raster counters and sync from the VGA timing block, plus snake/food state from the move logic.
- Stores body occupancy in an internal grid bitmap and emits pipelined 4-bit RGB with delay-matched HS/VS.
- Replaces the direct coordinate-compare drawing path at the top level.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- CELL_LOG2, 4, log2 of cell size in pixels (16x16 cells)
- GRID_W, 40, grid columns (H_ACTIVE >> CELL_LOG2)
- GRID_H, 30, grid rows (V_ACTIVE >> CELL_LOG2)

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  synchronous active-high reset
- hCount  in  10  raster column from VGA timing
- vCount  in  10  raster line from VGA timing
- hsIn  in  1  HS from VGA timing, undelayed
- vsIn  in  1  VS from VGA timing, undelayed
- wrValid  in  1  occupancy write request
- wrReady  out  1  write accepted when high with wrValid
- wrX  in  6  write cell column
- wrY  in  5  write cell row
- wrSet  in  1  1 = mark occupied (new head), 0 = clear (tail release)
- headX  in  6  head cell column
- headY  in  5  head cell row
- foodX  in  6  food cell column
- foodY  in  5  food cell row
- wallsOn  in  1  draw border wall cells
- gameOver  in  1  game-over tint enable
- clearStart  in  1  one-cycle pulse: wipe bitmap
- clearBusy  out  1  high while the wipe runs
- HS  out  1  HS delayed to align with RGB
- VS  out  1  VS delayed to align with RGB
- Red  out  4  pixel red
- Green  out  4  pixel green
- Blue  out  4  pixel blue

Behaviour:
- Bitmap: GRID_W*GRID_H = 1200 bits, 1 write port, 1 synchronous read port, linear address y*GRID_W+x.
- FSM has two states, IDLE and CLEAR.
  - reset forces CLEAR with clear address 0. It also restarts a wipe already in progress from 0.
  - CLEAR writes 0 to one address per cycle. It returns to IDLE after address 1199 is written, so CLEAR lasts 1200 cycles.
  - clearStart in IDLE: go to CLEAR next cycle from address 0.
  - clearStart in CLEAR: ignored; the wipe is not restarted.
- wrReady = 1 in IDLE, 0 in CLEAR; clearBusy = inverse of wrReady. After reset, wrReady=0, clearBusy=1.
- Write handshake:
  - Fires on the cycle where wrValid && wrReady; the bit holds wrSet from the next cycle.
  - Out-of-range requests (wrX >= GRID_W or wrY >= GRID_H) are accepted but not written.
  - Requests while wrReady=0 are not accepted; the producer must hold them.
- Render pipeline, latency exactly 2 cycles from hCount/vCount/hsIn/vsIn to RGB/HS/VS:
  - Stage 1 registers the active flag (hCount < H_ACTIVE && vCount < V_ACTIVE), cell x = hCount>>CELL_LOG2, cell y = vCount>>CELL_LOG2 and the sync bits, and issues the bitmap read.
  - Stage 2 classifies the pixel and registers RGB.
- Same-cycle read and write to one address returns the old value (read-before-write). Reads are not stalled by writes or by CLEAR.
- Pixel classification priority, first match wins:
  1. inactive: 0/0/0
  2. head cell match: 0/F/0
  3. body bit set: 0/8/0
  4. food cell match: F/0/0
  5. wallsOn and border cell (x=0, x=GRID_W-1, y=0, y=GRID_H-1): 8/8/8
  6. otherwise background: 0/0/0
- gameOver=1: every head/body/food/wall pixel outputs F/0/0; background and inactive stay 0.
- headX/headY/foodX/foodY/wallsOn/gameOver are sampled in stage 2 with no extra delay.
- Reset values: Red=Green=Blue=0; HS=VS=1; pipeline active flags 0.

Test Plan:
- Reset, then idle: clearBusy=1 and wrReady=0 for exactly 1200 cycles, then wrReady=1; every active pixel with wallsOn=0 and head/food off-grid (e.g. 63/31) is 0/0/0.
- Write wrX=5, wrY=3, wrSet=1, then raster hCount=80..95, vCount=48..63: RGB=0/8/0 two cycles after each count; hCount=96 gives 0/0/0.
- headX=5, headY=3 with body bit set: pixel (80,48) is 0/F/0. Set gameOver=1: it becomes F/0/0. A background pixel stays 0.
- wallsOn=1: pixel (0,0) and (639,479) are 8/8/8; (640,0) and (0,480) are 0/0/0. hsIn/vsIn toggles appear on HS/VS exactly 2 cycles later.
- Write a cell while that cell is read in the same cycle: old value is rendered that cycle, new value on the next read. Out-of-range write (wrX=40) is accepted (wrReady=1) and leaves the bitmap unchanged.
- clearStart mid-game, then clearStart again 100 cycles later: busy runs 1200 cycles total from the first pulse. Write offered during busy is held off until wrReady=1, then lands. Reset asserted at cycle 600 of the wipe restarts a full 1200-cycle wipe.
